// File: rtl/cmpx_stream.sv
// cmpx_stream: streaming check-node min/min2/index finder.
// Folds P magnitudes per beat over a runtime-selected row degree.
module cmpx_stream #(
  parameter int data_w = 9,
  parameter int P      = 4,
  parameter int D_MAX  = 32,
  parameter int idx_w  = 5,
  parameter int deg_w  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [deg_w-1:0]    deg,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_w*P-1:0] in,
  input  logic [P-1:0]        in_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_w-1:0]   min,
  output logic [data_w-1:0]   min2,
  output logic [idx_w-1:0]    min_idx,
  output logic                sign_par,
  output logic                busy
);

  localparam int NBEAT = (D_MAX + P - 1) / P;
  localparam int BW    = $clog2(NBEAT + 1);
  localparam int GW    = deg_w + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [deg_w-1:0]    r_deg;
  logic [BW-1:0]       r_beat;
  logic [data_w-1:0]   r_acc_min;
  logic [data_w-1:0]   r_acc_min2;
  logic [idx_w-1:0]    r_acc_idx;
  logic                r_acc_sign;
  logic [data_w-1:0]   r_min;
  logic [data_w-1:0]   r_min2;
  logic [idx_w-1:0]    r_min_idx;
  logic                r_sign_par;
  logic                r_out_valid;

  logic [data_w-1:0]   w_min;
  logic [data_w-1:0]   w_min2;
  logic [idx_w-1:0]    w_idx;
  logic                w_sign;
  logic [GW-1:0]       w_g;
  logic [data_w-1:0]   w_v;
  logic                w_last;
  logic                w_accept;
  logic [deg_w-1:0]    w_deg_clamp;

  assign in_ready  = (r_state == S_ACCUM);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign min       = r_min;
  assign min2      = r_min2;
  assign min_idx   = r_min_idx;
  assign sign_par  = r_sign_par;

  assign w_accept = in_valid && (r_state == S_ACCUM);

  // Degrees above the supported maximum are treated as D_MAX.
  assign w_deg_clamp = (deg > deg_w'(D_MAX)) ? deg_w'(D_MAX) : deg;

  // The beat is final once it covers global index deg-1.
  assign w_last =
    ((GW'(r_beat) + GW'(1)) * GW'(P)) >= {1'b0, r_deg};

  // Fold lanes in ascending order so ties keep the lowest index.
  always_comb begin
    w_min  = r_acc_min;
    w_min2 = r_acc_min2;
    w_idx  = r_acc_idx;
    w_sign = r_acc_sign;
    w_g    = '0;
    w_v    = '0;
    for (int k = 0; k < P; k++) begin
      w_g = GW'(r_beat) * GW'(P) + GW'(k);
      w_v = in[k*data_w +: data_w];
      if (w_g < {1'b0, r_deg}) begin
        if (w_v < w_min) begin
          w_min2 = w_min;
          w_min  = w_v;
          w_idx  = idx_w'(w_g);
        end else if (w_v < w_min2) begin
          w_min2 = w_v;
        end
        w_sign = w_sign ^ in_sign[k];
      end
    end
  end

  // Row control FSM with registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_deg       <= '0;
      r_beat      <= '0;
      r_acc_min   <= '0;
      r_acc_min2  <= '0;
      r_acc_idx   <= '0;
      r_acc_sign  <= 1'b0;
      r_min       <= '0;
      r_min2      <= '0;
      r_min_idx   <= '0;
      r_sign_par  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && (deg != '0)) begin
            r_deg      <= w_deg_clamp;
            r_beat     <= '0;
            r_acc_min  <= '1;
            r_acc_min2 <= '1;
            r_acc_idx  <= '0;
            r_acc_sign <= 1'b0;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc_min  <= w_min;
            r_acc_min2 <= w_min2;
            r_acc_idx  <= w_idx;
            r_acc_sign <= w_sign;
            if (w_last) begin
              r_min       <= w_min;
              r_min2      <= w_min2;
              r_min_idx   <= w_idx;
              r_sign_par  <= w_sign;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmpx_stream.md
Name: cmpx_stream

Overview:
- Streaming successor of the fixed-degree check-node min finder.
- Accepts check-node magnitudes P lanes per beat over several beats, for a runtime-selected degree deg of up to D_MAX.
- Produces min, min2, min_idx and the XOR parity of all input signs, registered, using a valid/ready output handshake.
- Sits in the CNU between the VNU-message buffer read port and the min-sum output stage; supports irregular codes whose row degree varies per row.

Parameters:
- data_w, 9, magnitude width in bits
- P, 4, lanes (magnitudes) accepted per beat
- D_MAX, 32, maximum supported check-node degree
- idx_w, 5, width of min_idx; must satisfy 2^idx_w >= D_MAX
- deg_w, 6, width of the deg input; must satisfy 2^deg_w > D_MAX

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a row; latches deg
- deg  in  deg_w  row degree, sampled on an accepted start
- in_valid  in  1  beat valid
- in_ready  out  1  block accepts a beat this cycle
- in  in  data_w*P  magnitudes; lane k at [k*data_w +: data_w]
- in_sign  in  P  sign bits; lane k at bit k
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts the result
- min  out  data_w  smallest magnitude
- min2  out  data_w  second smallest magnitude
- min_idx  out  idx_w  global index of min
- sign_par  out  1  XOR of all in-degree signs
- busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset, synchronous and active-high, takes priority over every input:
  - state = IDLE
  - min, min2, min_idx, sign_par, out_valid = 0
  - internal accumulators cleared
- Reset mid-row aborts the row with no output.
- States:
  - IDLE: in_ready=0, out_valid=0.
    - start with deg in 1..D_MAX: latch deg, beat counter=0, acc_min=acc_min2=all ones, acc_idx=0, acc_sign=0; go to ACCUM.
    - start with deg=0: ignored, stay in IDLE.
    - start with deg>D_MAX: deg clamped to D_MAX.
  - ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready.
    - Lane k of beat b has global index g = b*P + k. Lanes with g >= deg are masked: magnitude treated as all ones, sign excluded, never selected as min.
    - Per beat, fold the P unmasked values into (acc_min, acc_min2, acc_idx) with strict less-than:
      - v < acc_min: min2 <= acc_min, min <= v, idx <= g.
      - otherwise, if v < acc_min2: min2 <= v.
      - Lanes are folded in ascending k within a beat, so on ties the lowest global index wins min and the equal value becomes min2.
    - acc_sign ^= XOR of unmasked signs.
    - Final beat is the accepted beat with (b+1)*P >= deg. After it, load the outputs from the updated accumulators, set out_valid=1, go to DONE.
    - start is ignored in ACCUM.
  - DONE: in_ready=0; outputs held stable.
    - out_valid && out_ready: out_valid <= 0, go to IDLE.
    - start is ignored in DONE, including the handshake cycle.
- Latency: outputs valid the cycle after the final beat is accepted. A row takes ceil(deg/P) accepted beats + 1 cycle + handshake wait + 1 IDLE cycle.
- in_valid low in ACCUM stalls without any state change.
- deg=1: min = in lane 0, min2 = all ones, min_idx = 0.
- Beat counter width is ceil(log2(ceil(D_MAX/P)+1)) and never wraps, since the final beat always terminates the row.
- busy = (state != IDLE).
- Combinational fold is P-deep sequential compare per beat; no pipelining inside a beat.

Test Plan:
- Reset then deg=7, P=4, beats {5,3,8,2},{9,2,4,X} with signs all 0 except lane1 of beat0 -> min=2, min2=2, min_idx=3, sign_par=1, out_valid the cycle after beat 2; lane 3 of beat 2 ignored even when X=0.
- deg=1, single beat {6,0,0,0} -> min=6, min2=511, min_idx=0.
- deg=32, in_valid toggled 1/0 for 8 beats, value at g = 40-g -> min=9, min2=10, min_idx=31; stall cycles change nothing.
- Result produced with out_ready held low 5 cycles while start pulses -> outputs stable, start ignored; after out_ready=1, IDLE then a new start accepted.
- rst asserted during beat 2 of a deg=12 row -> all outputs 0 next cycle, state IDLE, no out_valid; a following deg=4 row computes correctly from fresh accumulators.
- start with deg=0 -> stays IDLE; deg=40 -> clamped to 32, requires exactly 8 beats.
